sync_pulse_mc: RTL and testbench
================================

# sync_pulse_mc

Multi-channel, parametrised successor to the single-channel pulse synchronizer. It brings CH asynchronous or foreign-domain signals into one clock domain through a configurable synchronizer chain and an optional glitch filter. Each channel has a selectable edge mode, a one-cycle event pulse, a sticky pending flag with acknowledge, and a saturating event counter. It sits at the boundary between external or foreign-clock event sources and a register or interrupt block in the `clk` domain.

## Interface
- `CH`, 4: number of independent channels, 1..32.
- `SYNC_STAGES`, 2: synchronizer flops per channel, at least 2.
- `FILT_CYC`, 0: glitch-filter length in cycles; 0 bypasses the filter.
- `CNT_W`, 8: event counter width per channel, 1..16.
- `clk` in 1: single system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `async_in` in CH: raw inputs, asynchronous to `clk`.
- `mode` in 2*CH: per-channel edge mode at bits [2i+1:2i]. 00 = rise, 01 = fall, 10 = both, 11 = events disabled.
- `ack` in CH: per-channel acknowledge; clears pend/cnt/ovf.
- `pose_b_out` out CH: one-cycle event pulse per channel.
- `level_b_out` out CH: synchronized, filtered level.
- `pend` out CH: sticky event-pending flag.
- `cnt` out CH*CNT_W: saturating event count; channel i at bits [CNT_W*i +: CNT_W].
- `ovf` out CH: sticky flag, set when an event is dropped because the counter is saturated.

## Operation
- **Sync chain:** per-channel shift register of SYNC_STAGES flops, reset 0. The last stage is `s`.
- **Filter, FILT_CYC = 0:** filtered level `f` = `s`.
- **Filter, FILT_CYC > 0:**
  - Per-channel counter fcnt, sized $clog2(FILT_CYC+1), reset 0.
  - While `s` != `f`, fcnt increments each cycle.
  - When `s` != `f` and fcnt == FILT_CYC-1: `f` <= `s` and fcnt <= 0.
  - Whenever `s` == `f`, fcnt <= 0. A glitch shorter than FILT_CYC cycles therefore never reaches `f`.
  - `f` resets to 0.
- **Level output:** `level_b_out` = `f`.
- **Edge detect:** `f_d` <= `f` (reset 0).
  - rise = `f` & ~`f_d`; fall = ~`f` & `f_d`.
  - `evt` is selected from rise/fall per `mode`: 00 → rise, 01 → fall, 10 → rise | fall, 11 → 0.
- **Pulse output:** `pose_b_out` <= `evt` (registered). It is high for exactly one cycle per qualifying `f` transition.
- **Pending flag:** `pend` <= `evt` | (`pend` & ~`ack`). When `evt` and `ack` occur in the same cycle, `pend` = 1.
- **Counter:**
  - On `evt` with `cnt` < max: `cnt` + 1.
  - On `evt` with `cnt` == max: `cnt` holds and `ovf` <= 1.
  - `ack` alone: `cnt` <= 0, `ovf` <= 0.
  - `ack` and `evt` in the same cycle: `cnt` <= 1, `ovf` <= 0.
- **Mode changes:** take effect on the next edge and never create an event themselves. `level_b_out` tracks the input in every mode, including 11.
- **Channel independence:** channels are fully independent; there is no cross-channel arbitration.

## Timing
- **Reset:** asserting `rstn` clears every flop asynchronously. All outputs read 0 during reset and immediately after release.
- **Level latency:** an `async_in` change sampled at edge k appears on `level_b_out` after edge k+SYNC_STAGES-1+FILT_CYC.
- **Event latency:**
  - `pose_b_out`, `pend` and `cnt` update one edge after `level_b_out` changes.
  - With the defaults, edge k+2.
- **Minimum separation:** input pulses must be at least FILT_CYC+1 cycles wide and separated by at least the same; both cycle counts are in `clk` periods. Shorter activity may be merged or dropped; that is legal, not an error.
- **Reset mid-operation:** in-flight synchronizer and filter state is discarded. If `async_in` is high at release, `level_b_out` rises after the normal latency, and a rise event is generated (rise/both modes).
- **Ack timing:** `ack` is sampled each edge and is level-sensitive. Holding `ack` high keeps `cnt` at 0 or 1, and leaves `pend` set only in cycles with `evt`.

## Structure
- **Package `sync_pulse_pkg`:**
  - Mode encoding as a 2-bit enum: MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF.
  - A `SYNC_STAGES_MIN = 2` constant.
- **Sub-module `sync_pulse_ch`:** one channel, containing the sync chain, filter, edge detect, pend and counter.
- **Top level:** a generate loop of CH instances, plus parameter legality checks (`$error` on SYNC_STAGES < 2 or CH outside range).

## Test plan
- **Fixed pulse, default parameters:** reset, then hold `async_in[0]` high for 10 cycles with mode 00.
  - `level_b_out[0]` rises 2 edges after sampling.
  - `pose_b_out[0]` is a single pulse on the following edge.
  - `pend[0]` = 1, `cnt[0]` = 1.
  - After the falling edge, `cnt[0]` stays 1.
- **Mode sweep:** ch1 in mode 10, ch2 in mode 01, ch3 in mode 11, with the same 3 high pulses on each.
  - `cnt` = 6, 3, 0 respectively.
  - `level_b_out` toggles identically on all three.
- **Glitch filter, FILT_CYC = 4:**
  - 3-cycle glitch: no `level_b_out` change, `cnt` = 0.
  - 5-cycle pulse: `level_b_out` high, latency 2+4 edges, `cnt` = 1.
- **Saturation and ack, CNT_W = 2:**
  - 5 rise events: `cnt` = 3, `ovf` = 1.
  - `ack` together with a 6th event: `cnt` = 1, `ovf` = 0, `pend` = 1.
  - `ack` alone: `pend` = 0, `cnt` = 0.
- **Reset mid-operation:** assert `rstn` low while `async_in` is high and `cnt` = 2.
  - All outputs go 0 at once, asynchronously.
  - After release with `async_in` still high: one rise event, `cnt` = 1.
- **Random soak:** 100 random-width pulses at least FILT_CYC+1 cycles apart on all channels. A scoreboard reference model matches `pose_b_out` count and `cnt` per channel and mode.

Source files
------------

// File: rtl/sync_pulse_pkg.sv
// Shared types and constants for the multi-channel pulse synchronizer.
package sync_pulse_pkg;

   // Per-channel edge qualification, 2 bits per channel on the mode bus.
   typedef enum logic [1:0] {
      MODE_RISE = 2'b00,
      MODE_FALL = 2'b01,
      MODE_BOTH = 2'b10,
      MODE_OFF  = 2'b11
   } mode_e;

   // Fewer than two flops leaves no settling time for a metastable first stage.
   localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_pulse_ch.sv
// One channel: synchronizer chain, optional glitch filter, edge detect,
// registered event pulse, sticky pending flag and saturating event counter.
module sync_pulse_ch
   import sync_pulse_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC    = 0,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             async_in,
   input  logic [1:0]       mode,
   input  logic             ack,
   output logic             pose_b_out,
   output logic             level_b_out,
   output logic             pend,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   s_p0;
   logic                   level_p1;
   logic                   level_p2;
   logic                   rise;
   logic                   fall;
   logic                   evt;
   mode_e                  mode_sel;

   // Shift the raw input through the synchronizer chain.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_p0 <= '0;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], async_in};
      end
   end

   assign s_p0 = sync_p0[SYNC_STAGES-1];

   // ---- stage boundary: synchronized level -> filtered level ----
   if (FILT_CYC == 0) begin : g_nofilt
      assign level_p1 = s_p0;
   end else begin : g_filt
      localparam int FW = $clog2(FILT_CYC + 1);
      logic [FW-1:0] fcnt;
      logic          filt_q;

      // Adopt the new level only once it has disagreed for FILT_CYC cycles.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            fcnt   <= '0;
            filt_q <= 1'b0;
         end else if (s_p0 != filt_q) begin
            if (fcnt == FW'(FILT_CYC - 1)) begin
               filt_q <= s_p0;
               fcnt   <= '0;
            end else begin
               fcnt <= fcnt + FW'(1);
            end
         end else begin
            fcnt <= '0;
         end
      end

      assign level_p1 = filt_q;
   end

   assign level_b_out = level_p1;

   // ---- stage boundary: filtered level -> delayed copy for edge detect ----
   // Keep the previous filtered level so transitions can be detected.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         level_p2 <= 1'b0;
      end else begin
         level_p2 <= level_p1;
      end
   end

   assign rise     = level_p1 & ~level_p2;
   assign fall     = ~level_p1 & level_p2;
   assign mode_sel = mode_e'(mode);

   // Qualify the detected transitions by the channel's edge mode.
   always_comb begin
      evt = 1'b0;
      case (mode_sel)
         MODE_RISE: evt = rise;
         MODE_FALL: evt = fall;
         MODE_BOTH: evt = rise | fall;
         default:   evt = 1'b0;
      endcase
   end

   // ---- stage boundary: event -> pulse, pending flag and counter ----
   // Event bookkeeping; an event in the acknowledge cycle survives the clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pose_b_out <= 1'b0;
         pend       <= 1'b0;
         cnt        <= '0;
         ovf        <= 1'b0;
      end else begin
         pose_b_out <= evt;
         pend       <= evt | (pend & ~ack);
         if (ack) begin
            cnt <= evt ? CNT_W'(1) : '0;
            ovf <= 1'b0;
         end else if (evt) begin
            if (cnt == CNT_MAX) begin
               ovf <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/sync_pulse_mc.sv
// Multi-channel pulse synchronizer: CH independent sync_pulse_ch instances
// bringing foreign-domain events into the clk domain.
module sync_pulse_mc
   import sync_pulse_pkg::*;
#(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC    = 0,
   parameter int CNT_W       = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [CH-1:0]       async_in,
   input  logic [2*CH-1:0]     mode,
   input  logic [CH-1:0]       ack,
   output logic [CH-1:0]       pose_b_out,
   output logic [CH-1:0]       level_b_out,
   output logic [CH-1:0]       pend,
   output logic [CH*CNT_W-1:0] cnt,
   output logic [CH-1:0]       ovf
);

   // Reject parameter sets the channel logic cannot support.
   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
      $error("sync_pulse_mc: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
   end
   if (CH < 1 || CH > 32) begin : g_bad_ch
      $error("sync_pulse_mc: CH must be in 1..32");
   end
   if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt
      $error("sync_pulse_mc: CNT_W must be in 1..16");
   end
   if (FILT_CYC < 0) begin : g_bad_filt
      $error("sync_pulse_mc: FILT_CYC must not be negative");
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      sync_pulse_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_CYC    (FILT_CYC),
         .CNT_W       (CNT_W)
      ) u_ch (
         .clk         (clk),
         .rstn        (rstn),
         .async_in    (async_in[i]),
         .mode        (mode[2*i +: 2]),
         .ack         (ack[i]),
         .pose_b_out  (pose_b_out[i]),
         .level_b_out (level_b_out[i]),
         .pend        (pend[i]),
         .cnt         (cnt[CNT_W*i +: CNT_W]),
         .ovf         (ovf[i])
      );
   end

endmodule

// File: tb/tb_sync_pulse_mc.sv
// Directed and randomized bench for sync_pulse_mc. Two instances: defaults
// (no filter, 8-bit counters) and a filtered, 2-bit-counter variant.
module tb_sync_pulse_mc;

   localparam int CH    = 4;
   localparam int LAT_A = 1;   // SYNC_STAGES-1+FILT_CYC for instance a
   localparam int LAT_B = 5;   // SYNC_STAGES-1+FILT_CYC for instance b

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn;
   logic [CH-1:0] a_in, a_ack, a_pose, a_level, a_pend, a_ovf;
   logic [7:0]    a_mode;
   logic [31:0]   a_cnt;
   logic [CH-1:0] b_in, b_ack, b_pose, b_level, b_pend, b_ovf;
   logic [7:0]    b_mode;
   logic [7:0]    b_cnt;

   sync_pulse_mc #(.CH(CH), .SYNC_STAGES(2), .FILT_CYC(0), .CNT_W(8)) dut_a (
      .clk(clk), .rstn(rstn), .async_in(a_in), .mode(a_mode), .ack(a_ack),
      .pose_b_out(a_pose), .level_b_out(a_level), .pend(a_pend), .cnt(a_cnt), .ovf(a_ovf));

   sync_pulse_mc #(.CH(CH), .SYNC_STAGES(2), .FILT_CYC(4), .CNT_W(2)) dut_b (
      .clk(clk), .rstn(rstn), .async_in(b_in), .mode(b_mode), .ack(b_ack),
      .pose_b_out(b_pose), .level_b_out(b_level), .pend(b_pend), .cnt(b_cnt), .ovf(b_ovf));

   int errors = 0;
   int checks = 0;
   int pc_a[CH];
   int pc_b[CH];
   logic [CH-1:0] hist[$];
   bit  soak_on = 0;
   int  lvl_err = 0;
   int  pose_err = 0;
   int  rem[CH];
   logic [CH-1:0] lv;
   int  np[CH];
   bit  done;
   int  cyc;
   int  ev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Event rule straight from the edge-mode definition.
   function automatic logic evt_of(input logic cur, input logic prev, input logic [1:0] m);
      case (m)
         2'b00:   return cur & ~prev;
         2'b01:   return ~cur & prev;
         2'b10:   return cur ^ prev;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int events_for(input logic [1:0] m, input int pulses);
      case (m)
         2'b00, 2'b01: return pulses;
         2'b10:        return 2 * pulses;
         default:      return 0;
      endcase
   endfunction

   // One clock: record the sampled input, advance, tally pulses and, during
   // the soak, compare level/pulse with the delayed input history.
   task automatic step();
      int n;
      hist.push_back(a_in);
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
         pc_a[c] += a_pose[c] ? 1 : 0;
         pc_b[c] += b_pose[c] ? 1 : 0;
      end
      if (soak_on) begin
         n = hist.size() - 1;
         for (int c = 0; c < CH; c++) begin
            if (n >= LAT_A + 2) begin
               if (a_level[c] !== hist[n-LAT_A][c]) lvl_err++;
               if (a_pose[c] !== evt_of(hist[n-1-LAT_A][c], hist[n-2-LAT_A][c], a_mode[2*c +: 2]))
                  pose_err++;
            end
            if (n >= LAT_B + 2) begin
               if (b_level[c] !== hist[n-LAT_B][c]) lvl_err++;
               if (b_pose[c] !== evt_of(hist[n-1-LAT_B][c], hist[n-2-LAT_B][c], b_mode[2*c +: 2]))
                  pose_err++;
            end
         end
      end
   endtask

   task automatic clear_counts();
      for (int c = 0; c < CH; c++) begin
         pc_a[c] = 0;
         pc_b[c] = 0;
      end
   endtask

   initial begin
      rstn = 1'b0;
      a_in = '0; a_mode = '0; a_ack = '0;
      b_in = '0; b_mode = '0; b_ack = '0;
      clear_counts();

      // Reset state
      step(); step();
      chk("rst_a_level", a_level, 0);
      chk("rst_a_pose", a_pose, 0);
      chk("rst_a_pend", a_pend, 0);
      chk("rst_a_cnt", a_cnt, 0);
      chk("rst_a_ovf", a_ovf, 0);
      chk("rst_b_cnt", b_cnt, 0);
      rstn = 1'b1;
      step();
      chk("rel_a_pose", a_pose, 0);
      chk("rel_a_cnt", a_cnt, 0);
      chk("rel_b_pend", b_pend, 0);

      // Fixed 10-cycle pulse on channel 0, rise mode
      clear_counts();
      a_in[0] = 1'b1;
      step();
      chk("t1_level_e1", a_level[0], 0);
      step();
      chk("t1_level_e2", a_level[0], 1);
      chk("t1_pose_e2", a_pose[0], 0);
      step();
      chk("t1_pose_e3", a_pose[0], 1);
      chk("t1_pend_e3", a_pend[0], 1);
      chk("t1_cnt_e3", a_cnt[7:0], 1);
      step();
      chk("t1_pose_e4", a_pose[0], 0);
      repeat (6) step();
      a_in[0] = 1'b0;
      repeat (5) step();
      chk("t1_level_end", a_level[0], 0);
      chk("t1_cnt_end", a_cnt[7:0], 1);
      chk("t1_pulses", pc_a[0], 1);

      // Mode sweep: ch1 both, ch2 fall, ch3 off
      a_mode = 8'b11_01_10_00;
      for (int p = 0; p < 3; p++) begin
         a_in[3:1] = 3'b111;
         repeat (2) step();
         chk("t2_level_hi", a_level[3:1], 3'b111);
         step();
         a_in[3:1] = 3'b000;
         repeat (3) step();
         chk("t2_level_lo", a_level[3:1], 3'b000);
      end
      repeat (4) step();
      chk("t2_cnt_both", a_cnt[15:8], 6);
      chk("t2_cnt_fall", a_cnt[23:16], 3);
      chk("t2_cnt_off", a_cnt[31:24], 0);
      chk("t2_pend", a_pend[3:1], 3'b011);

      // Switching mode while the level is steady creates no event
      a_in[3] = 1'b1;
      repeat (4) step();
      chk("t2_off_level", a_level[3], 1);
      a_mode[7:6] = 2'b00;
      repeat (3) step();
      chk("t2_modechg_cnt", a_cnt[31:24], 0);
      chk("t2_modechg_pend", a_pend[3], 0);
      a_in[3] = 1'b0;
      repeat (4) step();
      chk("t2_fall_in_rise", a_cnt[31:24], 0);

      // Glitch filter on instance b, channel 0
      clear_counts();
      b_in[0] = 1'b1;
      repeat (3) step();
      b_in[0] = 1'b0;
      repeat (10) step();
      chk("t3_glitch_level", b_level[0], 0);
      chk("t3_glitch_cnt", b_cnt[1:0], 0);
      chk("t3_glitch_pulses", pc_b[0], 0);
      b_in[0] = 1'b1;
      repeat (5) step();
      chk("t3_lat_early", b_level[0], 0);
      b_in[0] = 1'b0;
      step();
      chk("t3_lat_level", b_level[0], 1);
      step();
      chk("t3_pose", b_pose[0], 1);
      chk("t3_cnt", b_cnt[1:0], 1);
      repeat (12) step();
      chk("t3_cnt_end", b_cnt[1:0], 1);
      chk("t3_level_end", b_level[0], 0);
      chk("t3_pulses", pc_b[0], 1);

      // Saturation and acknowledge on instance b, channel 1
      for (int p = 0; p < 5; p++) begin
         b_in[1] = 1'b1;
         repeat (5) step();
         b_in[1] = 1'b0;
         repeat (5) step();
      end
      repeat (8) step();
      chk("t4_sat_cnt", b_cnt[3:2], 3);
      chk("t4_sat_ovf", b_ovf[1], 1);
      chk("t4_sat_pend", b_pend[1], 1);
      b_in[1] = 1'b1;
      repeat (5) step();
      b_in[1] = 1'b0;
      step();
      chk("t4_level6", b_level[1], 1);
      b_ack[1] = 1'b1;
      step();
      b_ack[1] = 1'b0;
      chk("t4_ackevt_pose", b_pose[1], 1);
      chk("t4_ackevt_cnt", b_cnt[3:2], 1);
      chk("t4_ackevt_ovf", b_ovf[1], 0);
      chk("t4_ackevt_pend", b_pend[1], 1);
      repeat (12) step();
      b_ack[1] = 1'b1;
      step();
      b_ack[1] = 1'b0;
      chk("t4_ack_pend", b_pend[1], 0);
      chk("t4_ack_cnt", b_cnt[3:2], 0);
      chk("t4_ack_ovf", b_ovf[1], 0);

      // Reset in the middle of activity on instance a, channel 0
      a_mode = '0;
      a_ack  = '1;
      step();
      a_ack  = '0;
      a_in[0] = 1'b1;
      repeat (4) step();
      a_in[0] = 1'b0;
      repeat (4) step();
      a_in[0] = 1'b1;
      repeat (5) step();
      chk("t5_pre_cnt", a_cnt[7:0], 2);
      chk("t5_pre_level", a_level[0], 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("t5_async_level", a_level, 0);
      chk("t5_async_cnt", a_cnt, 0);
      chk("t5_async_pend", a_pend, 0);
      chk("t5_async_b_cnt", b_cnt, 0);
      step(); step();
      chk("t5_held_cnt", a_cnt, 0);
      rstn = 1'b1;
      clear_counts();
      step();
      chk("t5_rel_level_e1", a_level[0], 0);
      step();
      chk("t5_rel_level_e2", a_level[0], 1);
      step();
      chk("t5_rel_pose", a_pose[0], 1);
      chk("t5_rel_cnt", a_cnt[7:0], 1);
      repeat (4) step();
      a_in[0] = 1'b0;
      repeat (4) step();
      chk("t5_end_cnt", a_cnt[7:0], 1);
      chk("t5_end_pulses", pc_a[0], 1);

      // Random soak: 25 pulses per channel (100 total) on both instances
      a_ack = '1; b_ack = '1; a_in = '0; b_in = '0;
      step();
      a_ack = '0; b_ack = '0;
      repeat (10) step();
      hist.delete();
      clear_counts();
      a_mode = 8'($urandom);
      b_mode = 8'($urandom);
      lv = '0;
      for (int c = 0; c < CH; c++) begin
         rem[c] = $urandom_range(5, 10);
         np[c]  = 0;
      end
      soak_on = 1;
      done = 0;
      cyc  = 0;
      while (!done && cyc < 5000) begin
         for (int c = 0; c < CH; c++) begin
            if (np[c] < 25 || lv[c]) begin
               rem[c]--;
               if (rem[c] == 0) begin
                  lv[c] = ~lv[c];
                  if (lv[c]) np[c]++;
                  rem[c] = $urandom_range(5, 10);
               end
            end
         end
         a_in = lv;
         b_in = lv;
         step();
         cyc++;
         done = 1;
         for (int c = 0; c < CH; c++) if (np[c] < 25 || lv[c]) done = 0;
      end
      chk("soak_budget", done, 1);
      repeat (15) step();
      soak_on = 0;
      for (int c = 0; c < CH; c++) begin
         ev = events_for(a_mode[2*c +: 2], 25);
         chk($sformatf("soak_a%0d_pulses", c), pc_a[c], ev);
         chk($sformatf("soak_a%0d_cnt", c), a_cnt[8*c +: 8], ev);
         chk($sformatf("soak_a%0d_ovf", c), a_ovf[c], 0);
         chk($sformatf("soak_a%0d_pend", c), a_pend[c], (ev > 0) ? 1 : 0);
         ev = events_for(b_mode[2*c +: 2], 25);
         chk($sformatf("soak_b%0d_pulses", c), pc_b[c], ev);
         chk($sformatf("soak_b%0d_cnt", c), b_cnt[2*c +: 2], (ev > 3) ? 3 : ev);
         chk($sformatf("soak_b%0d_ovf", c), b_ovf[c], (ev > 3) ? 1 : 0);
         chk($sformatf("soak_b%0d_pend", c), b_pend[c], (ev > 0) ? 1 : 0);
      end
      chk("soak_level_errs", lvl_err, 0);
      chk("soak_pulse_errs", pose_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
